// File: rtl/binary_op_pipe.sv
// Two-stage pipelined two-operand integer operator with valid/ready flow control.
// Stage 1 holds extended operands and opcode; stage 2 holds the registered result.
module binary_op_pipe #(
    parameter int WIDTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       out_result,
    output logic                 out_err,
    output logic [CNT_WIDTH-1:0] op_count
);

    localparam int EW = WIDTH + 1;
    localparam logic [EW-1:0] EW_V = EW'(EW);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SUB = 4'd4;
    localparam logic [3:0] OP_LT  = 4'd5;
    localparam logic [3:0] OP_LE  = 4'd6;
    localparam logic [3:0] OP_EQ  = 4'd7;
    localparam logic [3:0] OP_NE  = 4'd8;
    localparam logic [3:0] OP_GT  = 4'd9;
    localparam logic [3:0] OP_GE  = 4'd10;
    localparam logic [3:0] OP_SHL = 4'd11;
    localparam logic [3:0] OP_SHR = 4'd12;

    logic                 s1_valid_q, s1_valid_d;
    logic [3:0]           s1_op_q, s1_op_d;
    logic                 s1_signed_q, s1_signed_d;
    logic [EW-1:0]        s1_a_q, s1_a_d;
    logic [EW-1:0]        s1_b_q, s1_b_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [EW-1:0]        s2_result_q, s2_result_d;
    logic                 s2_err_q, s2_err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 s2_load;
    logic                 accept;
    logic [WIDTH-1:0]     sh;
    logic                 sh_big;
    logic                 a_neg;
    logic                 lt_c;
    logic                 eq_c;
    logic [EW-1:0]        result_c;
    logic                 err_c;

    assign s2_load  = !s2_valid_q | out_ready;
    assign in_ready = !s1_valid_q | !s2_valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_err    = s2_err_q;
    assign op_count   = cnt_q;

    // Shift amount is the raw, unsigned B operand.
    assign sh     = s1_b_q[WIDTH-1:0];
    assign sh_big = ({1'b0, sh} >= EW_V);
    assign a_neg  = s1_signed_q & s1_a_q[EW-1];
    assign eq_c   = (s1_a_q == s1_b_q);

    always_comb begin
        lt_c = 1'b0;
        if (s1_signed_q) begin
            lt_c = ($signed(s1_a_q) < $signed(s1_b_q));
        end else begin
            lt_c = (s1_a_q < s1_b_q);
        end
    end

    always_comb begin
        result_c = '0;
        err_c    = 1'b0;
        case (s1_op_q)
            OP_AND: result_c = s1_a_q & s1_b_q;
            OP_OR:  result_c = s1_a_q | s1_b_q;
            OP_XOR: result_c = s1_a_q ^ s1_b_q;
            OP_ADD: result_c = s1_a_q + s1_b_q;
            OP_SUB: result_c = s1_a_q - s1_b_q;
            OP_LT:  result_c = EW'(lt_c);
            OP_LE:  result_c = EW'(lt_c | eq_c);
            OP_EQ:  result_c = EW'(eq_c);
            OP_NE:  result_c = EW'(!eq_c);
            OP_GT:  result_c = EW'(!(lt_c | eq_c));
            OP_GE:  result_c = EW'(!lt_c);
            OP_SHL: result_c = sh_big ? '0 : (s1_a_q << sh);
            OP_SHR: begin
                if (sh_big) begin
                    result_c = a_neg ? '1 : '0;
                end else if (s1_signed_q) begin
                    result_c = $signed(s1_a_q) >>> sh;
                end else begin
                    result_c = s1_a_q >> sh;
                end
            end
            default: err_c = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_signed_d = s1_signed_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_err_d    = s2_err_q;
        cnt_d       = cnt_q;

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = result_c;
                s2_err_d    = err_c;
            end
        end

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d     = in_op;
                s1_signed_d = in_signed;
                s1_a_d      = in_signed ? {in_a[WIDTH-1], in_a} : {1'b0, in_a};
                s1_b_d      = in_signed ? {in_b[WIDTH-1], in_b} : {1'b0, in_b};
            end
        end

        // Counter saturates at all-ones.
        if (accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_signed_q <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_err_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_signed_q <= s1_signed_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_err_q    <= s2_err_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_binary_op_pipe.sv
// Randomized and directed bench for binary_op_pipe with a queue scoreboard
// and an integer-arithmetic reference model.
module tb_binary_op_pipe;

    localparam int W  = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic          in_signed;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W:0]    out_result;
    logic          out_err;
    logic [CW-1:0] op_count;

    binary_op_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_signed  (in_signed),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [5:0] exp_q[$];
    int         acc_cnt = 0;
    bit         kexp_en = 0;
    logic [5:0] kexp = '0;
    bit         rand_or = 0;
    bit         held_v = 0;
    logic [W:0] held_r;
    logic       held_e;

    // Reference: operand values as plain integers, result taken mod 2^(W+1).
    function automatic logic [5:0] model(int op, bit sg, int a, int b);
        int av;
        int bv;
        int r;
        bit e;
        av = (sg && a >= 8) ? a - 16 : a;
        bv = (sg && b >= 8) ? b - 16 : b;
        r  = 0;
        e  = 0;
        case (op)
            0:  r = av & bv;
            1:  r = av | bv;
            2:  r = av ^ bv;
            3:  r = av + bv;
            4:  r = av - bv;
            5:  r = (av <  bv) ? 1 : 0;
            6:  r = (av <= bv) ? 1 : 0;
            7:  r = (av == bv) ? 1 : 0;
            8:  r = (av != bv) ? 1 : 0;
            9:  r = (av >  bv) ? 1 : 0;
            10: r = (av >= bv) ? 1 : 0;
            11: r = (b >= W + 1) ? 0 : av * (1 << b);
            12: begin
                if (b >= W + 1) r = (av < 0) ? -1 : 0;
                else            r = av >>> b;
            end
            default: begin
                e = 1;
                r = 0;
            end
        endcase
        return {e, r[4:0]};
    endfunction

    // Stimulus side of the scoreboard: record every accepted operation.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_cnt = 0;
        end else if (in_valid && in_ready) begin
            if (kexp_en) exp_q.push_back(kexp);
            else exp_q.push_back(model(int'(in_op), in_signed,
                                       int'(in_a), int'(in_b)));
            acc_cnt++;
        end
    end

    // Monitor: compare delivered results and stability under stall.
    always @(negedge clk) begin
        logic [5:0] e;
        if (!rst_n) begin
            held_v = 0;
        end else begin
            if (held_v) begin
                checks++;
                if (!(out_valid && out_result == held_r && out_err == held_e)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b r=%b e=%b required v=1 r=%b e=%b",
                             out_valid, out_result, out_err, held_r, held_e);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: got r=%b e=%b required no output",
                             out_result, out_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_err, out_result} !== e) begin
                        errors++;
                        $display("FAIL result: got e=%b r=%b required e=%b r=%b",
                                 out_err, out_result, e[5], e[4:0]);
                    end
                end
            end
            held_v = out_valid && !out_ready;
            held_r = out_result;
            held_e = out_err;
        end
    end

    always @(posedge clk) begin
        if (rand_or) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic issue(input int op, input bit sg, input int a, input int b);
        bit acc;
        acc = 0;
        in_op     = op[3:0];
        in_signed = sg;
        in_a      = a[3:0];
        in_b      = b[3:0];
        in_valid  = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got no accept required accept");
        end
    endtask

    task automatic issue_k(input int op, input bit sg, input int a,
                           input int b, input logic [5:0] k);
        kexp_en = 1;
        kexp    = k;
        issue(op, sg, a, b);
        kexp_en = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_signed = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_err", out_err, 0);
        check("rst_op_count", op_count, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Latency: signed -8 + -8 = -16
        kexp_en   = 1;
        kexp      = 6'b0_10000;
        in_op     = 4'd3;
        in_signed = 1'b1;
        in_a      = 4'b1000;
        in_b      = 4'b1000;
        in_valid  = 1'b1;
        @(negedge clk);
        check("lat_accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kexp_en  = 0;
        @(negedge clk);
        check("lat_not_yet", out_valid, 0);
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("lat_result", out_result, 5'b10000);
        drain();

        issue_k(4, 0, 3, 5, 6'b0_11110);
        issue_k(5, 1, 15, 1, 6'b0_00001);
        issue_k(5, 0, 15, 1, 6'b0_00000);
        issue_k(12, 1, 8, 2, 6'b0_11110);
        issue_k(12, 0, 8, 2, 6'b0_00010);
        issue_k(11, 0, 1, 7, 6'b0_00000);
        issue_k(12, 1, 8, 9, 6'b0_11111);
        issue_k(14, 0, 3, 3, 6'b1_00000);
        issue_k(3, 0, 1, 2, 6'b0_00011);
        drain();

        // Reset with both stages full
        out_ready = 1'b0;
        issue(3, 0, 1, 1);
        issue(3, 0, 2, 2);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_op_count", op_count, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_stale", out_valid, 0);

        // Backpressure: five ADDs, output stalled for four edges
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) issue(3, 0, i, 2 * i + 1);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_accepts", acc_cnt, 2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_op_count", op_count, 5);

        // Counter saturation
        for (int i = 0; i < 10; i++) issue(0, 0, i, 15 - i);
        drain();
        check("cnt_at_max", op_count, CMAX);
        issue(1, 0, 5, 10);
        drain();
        check("cnt_sat", op_count, CMAX);

        // Random traffic with random backpressure
        rand_or = 1;
        for (int i = 0; i < 300; i++) begin
            issue($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15), $urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_or = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        check("rand_op_count", op_count, (acc_cnt > CMAX) ? CMAX : acc_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/binary_op_pipe.md
# binary_op_pipe

Pipelined, parametrised two-operand integer operator unit. It generalises the combinational bitwise, arithmetic, compare and shift operators to a configurable operand width with a runtime opcode and a runtime signed/unsigned mode. It adds a two-stage registered datapath with valid/ready flow control, error flagging and an operation counter. It sits between an operand producer and a result consumer in datapath blocks that need throughput of one operation per cycle under backpressure.

## Interface
- WIDTH, 4: operand width in bits; legal range 2..64.
- CNT_WIDTH, 16: width of the accepted-operation counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and opcode are presented.
- in_ready  out  1  unit accepts the presented operation this cycle.
- in_op  in  4  opcode; encoding given under Operation.
- in_signed  in  1  1 = operands are two's complement; 0 = unsigned.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B; for shifts it is the shift amount, always unsigned.
- out_valid  out  1  a result is presented.
- out_ready  in  1  consumer accepts the result this cycle.
- out_result  out  WIDTH+1  result; layout given under Operation.
- out_err  out  1  the opcode was illegal.
- op_count  out  CNT_WIDTH  number of accepted operations; saturates at its maximum.

## Operation
- Operand extension: both operands are extended to WIDTH+1 bits.
  - Sign-extended when in_signed=1; zero-extended otherwise.
  - All arithmetic is performed at WIDTH+1 bits.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR: bitwise on the extended operands.
  - 3 ADD, 4 SUB: wrap modulo 2^(WIDTH+1), so they are exact for any pair of in-range operands.
  - 5 LT, 6 LE, 7 EQ, 8 NE, 9 GT, 10 GE: result is {WIDTH'b0, flag}; signedness comes from in_signed.
  - 11 SHL: extended A shifted left by in_b.
  - 12 SHR: extended A shifted right by in_b; arithmetic when in_signed=1, logical otherwise.
- Shift saturation: for shift amounts ≥ WIDTH+1, SHL gives 0. SHR gives all-ones if in_signed=1 and A is negative, 0 otherwise.
- Illegal opcodes 13..15: out_result=0 and out_err=1. For every legal opcode out_err=0.
- Stage 1 (S1) registers the decoded opcode, the extended operands and in_signed.
- Stage 2 (S2) registers the computed result and err, and drives the out_* ports directly from its registers.
- Stage advance rules:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads when S1 is empty or S1 advances into S2.
  - in_ready = !s1_valid | !s2_valid | out_ready. It is purely combinational from registered state and out_ready; it does not depend on in_valid.
- Acceptance: an operation is accepted on a cycle with in_valid & in_ready.
- op_count: increments by 1 per accepted operation and holds at 2^CNT_WIDTH-1.
- No reordering, duplication or loss of operations. Results emerge in acceptance order.

## Timing
- Reset (rst_n=0, asynchronous):
  - s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_err=0, op_count=0.
  - in_ready=1 immediately after reset.
- Latency: an operation accepted at edge N appears on out_* after edge N+1, given no backpressure. Throughput is 1 per cycle.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_result and out_err hold stable.
  - With S1 and S2 both full and out_ready=0, in_ready=0 and no state changes.
  - Full pipe with out_ready=1 and in_valid=1: the output, the pipe shift and the new acceptance all complete on the same edge.
- Reset asserted mid-operation discards all in-flight operations. No result is emitted for them after reset release.
- op_count at saturation: further acceptances proceed normally and the count stays at its maximum.

## Test plan
- Signed ADD, WIDTH=4: a=4'b1000, b=4'b1000 -> out_result=5'b10000 (-16), out_err=0, out_valid two edges after acceptance.
- Unsigned SUB then signed LT:
  - SUB a=3, b=5 -> 5'b11110.
  - Signed LT a=4'hF, b=1 -> 5'b00001; unsigned LT with the same operands -> 5'b00000.
- Shifts:
  - Signed SHR a=4'b1000, b=2 -> 5'b11110.
  - Unsigned SHR, same operands -> 5'b00010.
  - SHL a=1, b=7 -> 0.
  - Signed SHR a=4'b1000, b=9 -> 5'b11111.
- Illegal opcode 14 -> out_result=0, out_err=1. The next legal operation returns out_err=0.
- Backpressure: stream 5 ADDs while holding out_ready=0 for 4 cycles.
  - in_ready must fall after 2 accepts.
  - All 5 results arrive in order, unchanged while stalled.
  - op_count=5.
- Assert rst_n low with both stages full -> out_valid=0 asynchronously, op_count=0, and no stale result after release.
